// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: data/HI-LO/EPC stall detection, exception flush
// priority, HI/LO unit busy tracking and a saturating stall-cycle counter.
`timescale 1ns/1ps
module pipe_ctrl #(
    parameter int unsigned MUL_CYC = 5,
    parameter int unsigned DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs,
    input  logic [1:0]  tuse_rt,
    input  logic [4:0]  A3E,
    input  logic [4:0]  A3M,
    input  logic [1:0]  tnew_E,
    input  logic [1:0]  tnew_M,
    input  logic        md_D,
    input  logic        start_E,
    input  logic        div_E,
    input  logic        eret_D,
    input  logic        mtc0_epc_E,
    input  logic        mtc0_epc_M,
    input  logic        exc_req,
    output logic        en_F,
    output logic        en_D,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_M,
    output logic        md_start,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] MUL_LD = 16'(MUL_CYC);
    localparam logic [15:0] DIV_LD = 16'(DIV_CYC);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        stall_rs, stall_rt, stall_md, stall_epc, stall;

    // Register 0 never carries a dependency, so it can never stall.
    assign stall_rs = (rs_D != 5'd0) &&
                      (((rs_D == A3E) && (tnew_E > tuse_rs)) ||
                       ((rs_D == A3M) && (tnew_M > tuse_rs)));
    assign stall_rt = (rt_D != 5'd0) &&
                      (((rt_D == A3E) && (tnew_E > tuse_rt)) ||
                       ((rt_D == A3M) && (tnew_M > tuse_rt)));
    assign stall_md  = md_D && (busy || start_E);
    assign stall_epc = eret_D && (mtc0_epc_E || mtc0_epc_M);
    assign stall     = stall_rs || stall_rt || stall_md || stall_epc;

    assign busy     = (state == BUSY);
    assign md_start = start_E && !exc_req && (state == IDLE);

    always_comb begin
        en_F    = 1'b1;
        en_D    = 1'b1;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        if (exc_req) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
            flush_M = 1'b1;
        end else if (stall) begin
            en_F    = 1'b0;
            en_D    = 1'b0;
            flush_E = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (md_start) begin
                    state_nx = BUSY;
                    cnt_nx   = div_E ? DIV_LD : MUL_LD;
                end
            end
            BUSY: begin
                // A zero count is treated like the last cycle so BUSY cannot hang.
                if (cnt <= 16'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (stall && !exc_req && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D, rt_D, A3E, A3M;
    logic [1:0]  tuse_rs, tuse_rt, tnew_E, tnew_M;
    logic        md_D, start_E, div_E, eret_D, mtc0_epc_E, mtc0_epc_M, exc_req;
    logic        en_F, en_D, flush_D, flush_E, flush_M, md_start, busy;
    logic [15:0] stall_cnt;

    int unsigned n_chk;
    int unsigned n_pass;

    pipe_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs    (tuse_rs),
        .tuse_rt    (tuse_rt),
        .A3E        (A3E),
        .A3M        (A3M),
        .tnew_E     (tnew_E),
        .tnew_M     (tnew_M),
        .md_D       (md_D),
        .start_E    (start_E),
        .div_E      (div_E),
        .eret_D     (eret_D),
        .mtc0_epc_E (mtc0_epc_E),
        .mtc0_epc_M (mtc0_epc_M),
        .exc_req    (exc_req),
        .en_F       (en_F),
        .en_D       (en_D),
        .flush_D    (flush_D),
        .flush_E    (flush_E),
        .flush_M    (flush_M),
        .md_start   (md_start),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_D = '0; rt_D = '0; A3E = '0; A3M = '0;
        tuse_rs = '0; tuse_rt = '0; tnew_E = '0; tnew_M = '0;
        md_D = 1'b0; start_E = 1'b0; div_E = 1'b0; eret_D = 1'b0;
        mtc0_epc_E = 1'b0; mtc0_epc_M = 1'b0; exc_req = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        check("rst_en_F", {31'b0, en_F}, 32'd1);
        check("rst_flush", {29'b0, flush_D, flush_E, flush_M}, 32'd0);
        check("rst_md_start", {31'b0, md_start}, 32'd0);

        // Register 0 never stalls
        A3E = 5'd0; rs_D = 5'd0; tnew_E = 2'd2; tuse_rs = 2'd0;
        #1;
        check("r0_en_F", {31'b0, en_F}, 32'd1);
        check("r0_flush_E", {31'b0, flush_E}, 32'd0);
        tick();
        check("r0_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        clear_inputs();

        // Load-use on rs via E stage
        A3E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs = 2'd1;
        #1;
        check("lu_en", {30'b0, en_F, en_D}, 32'd0);
        check("lu_flush", {29'b0, flush_D, flush_E, flush_M}, 32'b010);
        tick();
        clear_inputs();
        #1;
        check("lu_stall_cnt", {16'b0, stall_cnt}, 32'd1);
        check("lu_release", {31'b0, en_F}, 32'd1);

        // rt via M stage: tnew > tuse stalls, tnew == tuse does not
        rt_D = 5'd9; A3M = 5'd9; tnew_M = 2'd1; tuse_rt = 2'd0;
        #1;
        check("rtM_stall", {31'b0, en_F}, 32'd0);
        tick();
        tuse_rt = 2'd1;
        #1;
        check("rtM_equal", {31'b0, en_F}, 32'd1);
        tick();
        check("rtM_stall_cnt", {16'b0, stall_cnt}, 32'd2);
        clear_inputs();

        // Exception overrides a stall and blocks md_start
        A3E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs = 2'd1;
        exc_req = 1'b1; start_E = 1'b1;
        #1;
        check("exc_en", {30'b0, en_F, en_D}, 32'b11);
        check("exc_flush", {29'b0, flush_D, flush_E, flush_M}, 32'b111);
        check("exc_md_start", {31'b0, md_start}, 32'd0);
        tick();
        check("exc_stall_cnt", {16'b0, stall_cnt}, 32'd2);
        check("exc_busy", {31'b0, busy}, 32'd0);
        clear_inputs();

        // eret behind mtc0 EPC in M
        eret_D = 1'b1; mtc0_epc_M = 1'b1;
        #1;
        check("epc_stall", {31'b0, en_F}, 32'd0);
        tick();
        check("epc_stall_cnt", {16'b0, stall_cnt}, 32'd3);
        clear_inputs();

        // Divide: 10 busy cycles, md_D held stalled; start ignored and exc_req
        // not aborting along the way
        start_E = 1'b1; div_E = 1'b1; md_D = 1'b1;
        #1;
        check("div_md_start", {31'b0, md_start}, 32'd1);
        check("div_start_stall", {31'b0, en_F}, 32'd0);
        tick();
        start_E = 1'b0; div_E = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) start_E = 1'b1;
            if (i == 5) exc_req = 1'b1;
            #1;
            check($sformatf("div_busy_%0d", i), {31'b0, busy}, 32'd1);
            if (i == 3) check("div_restart_ign", {31'b0, md_start}, 32'd0);
            else if (i != 5) check($sformatf("div_stall_%0d", i), {31'b0, en_F}, 32'd0);
            tick();
            start_E = 1'b0; exc_req = 1'b0;
        end
        #1;
        check("div_done_busy", {31'b0, busy}, 32'd0);
        check("div_release", {31'b0, en_F}, 32'd1);
        check("div_stall_cnt", {16'b0, stall_cnt}, 32'd13);
        clear_inputs();

        // Reset in cycle 2 of a multiply
        start_E = 1'b1;
        tick();
        start_E = 1'b0;
        check("mul_c1_busy", {31'b0, busy}, 32'd1);
        tick();
        check("mul_c2_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_stall_cnt", {16'b0, stall_cnt}, 32'd0);

        // Full multiply: exactly 5 busy cycles
        start_E = 1'b1;
        tick();
        start_E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("mul_busy_%0d", i), {31'b0, busy}, 32'd1);
            tick();
        end
        check("mul_done", {31'b0, busy}, 32'd0);

        // Saturation after 0x10002 stalled cycles
        A3E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs = 2'd1;
        repeat (32'h10002) tick();
        check("sat_stall_cnt", {16'b0, stall_cnt}, 32'h0000FFFF);
        check("sat_still_stall", {31'b0, en_F}, 32'd0);
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
